// File: rtl/a3_regbank_pkg.sv
// rtl/a3_regbank_pkg.sv - shared types and sizes for the register bank read port
package a3_regbank_pkg;

  localparam int A3_NREGS     = 64;
  localparam int A3_SEL_W     = $clog2(A3_NREGS);
  localparam int A3_XLEN      = 64;
  localparam int A3_RSP_DEPTH = 2;

  typedef logic [A3_SEL_W-1:0] reg_sel_t;
  typedef logic [A3_XLEN-1:0]  reg_val_t;

  typedef struct packed {
    reg_sel_t sel;
    reg_val_t data;
  } rd_rsp_t;

  function automatic logic sel_hit(input logic we, input reg_sel_t a, input reg_sel_t b);
    return we && (a == b);
  endfunction

endpackage

// File: rtl/regrd_fifo.sv
// rtl/regrd_fifo.sv - in-order response queue for the register read port
module regrd_fifo
  import a3_regbank_pkg::*;
#(
  parameter int  DEPTH = A3_RSP_DEPTH,
  parameter type T     = rd_rsp_t,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  T                 i_push_data,
  input  logic             i_pop,
  output T                 o_pop_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap at DEPTH so non-power-of-two depths stay correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (i_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + 1'b1;
      end else if (i_pop && !i_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_pop_data = r_mem[r_rptr];
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_count    = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && o_full && !i_pop));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_pop && o_empty));

endmodule

// File: rtl/regbank_rdport.sv
// rtl/regbank_rdport.sv - register bank read port: S2 stage, write snoop, credit flow control
// Optional write-to-read forwarding is enabled by defining A3_REGRD_BYPASS_EN.
module regbank_rdport
  import a3_regbank_pkg::*;
#(
  parameter int  SEL_W     = A3_SEL_W,
  parameter int  XLEN      = A3_XLEN,
  parameter int  RSP_DEPTH = A3_RSP_DEPTH,
  localparam int PEND_W    = $clog2(RSP_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [SEL_W-1:0]  rd_req_sel,
  output logic [SEL_W-1:0]  rf_rd_sel,
  input  logic [XLEN-1:0]   rf_rd_data,
  input  logic              wr_we,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [XLEN-1:0]   wr_val,
  output logic              rd_rsp_valid,
  input  logic              rd_rsp_ready,
  output logic [SEL_W-1:0]  rd_rsp_sel,
  output logic [XLEN-1:0]   rd_rsp_data,
  output logic [PEND_W-1:0] rd_pending
);

  logic              w_accept;
  logic              w_pop;
  logic              w_wr_hit;
  logic              w_credit_ok;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [PEND_W-1:0] w_fifo_count;
  logic [XLEN-1:0]   w_s2_data;
  rd_rsp_t           w_push_rsp;
  rd_rsp_t           w_head_rsp;

  logic              r_s2_valid;
  logic [SEL_W-1:0]  r_s2_sel;
  logic [PEND_W-1:0] r_pending;

  assign rf_rd_sel = rd_req_sel;
  assign w_wr_hit  = sel_hit(wr_we, wr_sel, rd_req_sel);
  assign w_pop     = !w_fifo_empty && rd_rsp_ready;

  // r_pending counts the S2 read plus queued responses; a pop this cycle returns its slot now.
  assign w_credit_ok = (r_pending < PEND_W'(RSP_DEPTH)) || w_pop;

`ifdef A3_REGRD_BYPASS_EN
  assign rd_req_ready = reset && w_credit_ok;
`else
  assign rd_req_ready = reset && w_credit_ok && !w_wr_hit;
`endif

  assign w_accept = rd_req_valid && rd_req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_valid <= 1'b0;
      r_s2_sel   <= '0;
    end else begin
      r_s2_valid <= w_accept;
      if (w_accept) begin
        r_s2_sel <= rd_req_sel;
      end
    end
  end

`ifdef A3_REGRD_BYPASS_EN
  logic            r_s2_byp;
  logic [XLEN-1:0] r_s2_byp_val;

  // The array returns the pre-write value on a same-cycle collision, so keep the written value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_byp     <= 1'b0;
      r_s2_byp_val <= '0;
    end else if (w_accept) begin
      r_s2_byp     <= w_wr_hit;
      r_s2_byp_val <= wr_val;
    end
  end

  assign w_s2_data = r_s2_byp ? r_s2_byp_val : rf_rd_data;
`else
  logic w_unused_wr_val;

  assign w_unused_wr_val = ^wr_val;
  assign w_s2_data       = rf_rd_data;
`endif

  assign w_push_rsp.sel  = r_s2_sel;
  assign w_push_rsp.data = w_s2_data;

  regrd_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (rd_rsp_t)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .i_push      (r_s2_valid),
    .i_push_data (w_push_rsp),
    .i_pop       (w_pop),
    .o_pop_data  (w_head_rsp),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  assign rd_rsp_valid = !w_fifo_empty;
  assign rd_rsp_sel   = w_head_rsp.sel;
  assign rd_rsp_data  = w_head_rsp.data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
    end else if (w_accept && !w_pop) begin
      r_pending <= r_pending + 1'b1;
    end else if (w_pop && !w_accept) begin
      r_pending <= r_pending - 1'b1;
    end
  end

  assign rd_pending = r_pending;

  a_pending_tracks_pipe: assert property (@(posedge clk) disable iff (!reset)
    r_pending == PEND_W'(r_s2_valid) + w_fifo_count);

  a_push_has_room: assert property (@(posedge clk) disable iff (!reset)
    !(r_s2_valid && w_fifo_full && !w_pop));

endmodule
